// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 device-to-host receiver with an output byte FIFO.
//
// The raw ps2_clk/ps2_data pair is brought into the clk domain through two
// flops each. A third flop on the clock path finds falling edges. Every bit
// is sampled on a falling edge. Each 11-bit frame is checked: a start bit,
// 8 data bits sent LSB first, odd parity and a stop bit. Good bytes go into
// a circular FIFO. Bad frames and stalled frames produce a frame_err pulse.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   ps2_clk    raw PS/2 clock, asynchronous to clk
//   ps2_data   raw PS/2 data, asynchronous to clk
//   rd_en      pops the FIFO head while valid is high
//   data       FIFO head byte
//   valid      FIFO holds at least one byte
//   count      FIFO occupancy
//   overflow   sticky; a good byte was dropped because the FIFO was full
//   frame_err  one-cycle pulse on a parity error, stop error or timeout
module ps2_rx #(
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    input  logic                          rd_en,
    output logic [7:0]                    data,
    output logic                          valid,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow,
    output logic                          frame_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    // Synchronizers and edge detection. All flops reset high because an idle
    // PS/2 bus is pulled high; this stops reset release from looking like a
    // falling edge while the line is idle.
    logic clk_s1_reg, clk_s2_reg, clk_s3_reg;
    logic data_s1_reg, data_s2_reg;
    logic fall_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1_reg  <= 1'b1;
            clk_s2_reg  <= 1'b1;
            clk_s3_reg  <= 1'b1;
            data_s1_reg <= 1'b1;
            data_s2_reg <= 1'b1;
            fall_reg    <= 1'b0;
        end else begin
            clk_s1_reg  <= ps2_clk;
            clk_s2_reg  <= clk_s1_reg;
            clk_s3_reg  <= clk_s2_reg;
            data_s1_reg <= ps2_data;
            data_s2_reg <= data_s1_reg;
            fall_reg    <= clk_s3_reg & ~clk_s2_reg;
        end
    end

    // Frame receiver.
    state_t         state_reg;
    logic [2:0]     bit_cnt_reg;
    logic [7:0]     shreg_reg;
    logic           parity_reg;
    logic [TW-1:0]  timer_reg;
    logic           frame_err_reg;

    // The stop bit is on the synced data line during the STOP fall. Odd parity
    // means the data bits and the parity bit together hold an odd number of ones.
    logic frame_good;
    logic push;
    assign frame_good = data_s2_reg & (^{shreg_reg, parity_reg});
    assign push       = fall_reg && (state_reg == STOP) && frame_good;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            bit_cnt_reg   <= 3'd0;
            shreg_reg     <= 8'h00;
            parity_reg    <= 1'b0;
            timer_reg     <= '0;
            frame_err_reg <= 1'b0;
        end else begin
            frame_err_reg <= 1'b0;
            if (state_reg == IDLE) begin
                timer_reg <= '0;
                // A high bit seen while idle is line noise; ignore it silently.
                if (fall_reg && !data_s2_reg) begin
                    state_reg   <= DATA;
                    bit_cnt_reg <= 3'd0;
                end
            end else if (fall_reg) begin
                timer_reg <= '0;
                case (state_reg)
                    DATA: begin
                        shreg_reg   <= {data_s2_reg, shreg_reg[7:1]};
                        bit_cnt_reg <= bit_cnt_reg + 3'd1;
                        if (bit_cnt_reg == 3'd7) begin
                            state_reg <= PARITY;
                        end
                    end
                    PARITY: begin
                        parity_reg <= data_s2_reg;
                        state_reg  <= STOP;
                    end
                    default: begin
                        if (!frame_good) begin
                            frame_err_reg <= 1'b1;
                        end
                        state_reg <= IDLE;
                    end
                endcase
            end else if (timer_reg == TW'(TIMEOUT_CYC - 1)) begin
                // The device stalled mid-frame; drop the partial byte.
                frame_err_reg <= 1'b1;
                state_reg     <= IDLE;
                timer_reg     <= '0;
            end else begin
                timer_reg <= timer_reg + TW'(1);
            end
        end
    end

    // Output FIFO. Storage is reset so the head reads 0x00 out of reset.
    logic [7:0]    mem_reg [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          overflow_reg;
    logic          full, pop, wr_en;

    assign full  = (count_reg == CW'(FIFO_DEPTH));
    assign pop   = rd_en && (count_reg != '0);
    // When full, a pop in the same cycle frees the slot the push needs.
    assign wr_en = push && (!full || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_reg[i] <= 8'h00;
            end
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (wr_en) begin
                mem_reg[wr_ptr_reg] <= shreg_reg;
                wr_ptr_reg          <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            if (wr_en && !pop) begin
                count_reg <= count_reg + CW'(1);
            end else if (pop && !wr_en) begin
                count_reg <= count_reg - CW'(1);
            end
            if (push && full && !pop) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    assign data      = mem_reg[rd_ptr_reg];
    assign valid     = (count_reg != '0);
    assign count     = count_reg;
    assign overflow  = overflow_reg;
    assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_ps2_rx.sv
// Testbench for ps2_rx. Stimulus pushes expected bytes into a queue; a
// monitor pops the FIFO whenever auto_read is set and compares each byte.
module tb_ps2_rx;

    localparam int FIFO_DEPTH  = 8;
    localparam int TIMEOUT_CYC = 200;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       rd_en;
    logic [7:0] data;
    logic       valid;
    logic [3:0] count;
    logic       overflow;
    logic       frame_err;

    logic mon_rd = 1'b0;
    logic man_rd = 1'b0;
    assign rd_en = mon_rd | man_rd;

    ps2_rx #(.FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .rd_en(rd_en), .data(data), .valid(valid), .count(count),
        .overflow(overflow), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int         n_pass = 0;
    int         n_total = 0;
    int         err_cnt = 0;
    logic       prev_err = 1'b0;
    logic       auto_read = 1'b0;
    logic [7:0] exp_q [$];
    logic [23:0] hist = 24'h0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else n_pass++;
    endtask

    // Monitor: counts frame_err pulses, checks their width, drains the FIFO.
    initial begin
        forever begin
            @(negedge clk);
            mon_rd = 1'b0;
            if (frame_err === 1'b1) begin
                err_cnt++;
                chk("err_width", {31'd0, prev_err}, 32'd0);
            end
            prev_err = frame_err;
            if (auto_read && rst_n && valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_byte", {24'd0, data}, 32'hFFFF_FFFF);
                end else begin
                    $display("read byte %02h", data);
                    chk("stream", {24'd0, data}, {24'd0, exp_q.pop_front()});
                end
                hist = {hist[15:0], data};
                mon_rd = 1'b1;
            end
        end
    end

    // Sends the first n bits of a frame (LSB first). With pop_at_stop, rd_en is
    // held for exactly the clk edge that pushes the stop-bit frame: fall is high
    // after the 3rd edge following the ps2_clk drop, so the push is the 4th edge.
    task automatic send_bits(input logic [10:0] bits, input int n, input bit pop_at_stop);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ps2_data = bits[i];
            repeat (3) @(negedge clk);
            ps2_clk = 1'b0;
            if (pop_at_stop && i == 10) begin
                repeat (3) @(posedge clk);
                #1 man_rd = 1'b1;
                @(posedge clk);
                #1 man_rd = 1'b0;
            end
            repeat (6) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (3) @(negedge clk);
        end
        ps2_data = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit par_ok, input bit stop_b,
                             input bit pop_at_stop);
        logic par;
        par = par_ok ? ~(^b) : (^b);
        $display("send byte %02h parity_ok=%0d stop=%0d", b, par_ok, stop_b);
        send_bits({stop_b, par, b, 1'b0}, 11, pop_at_stop);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", exp_q.size(), 0);
        repeat (2) @(negedge clk);
        chk("drained_valid", {31'd0, valid}, 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_data"}, {24'd0, data}, 32'h0);
        chk({tag, "_valid"}, {31'd0, valid}, 32'd0);
        chk({tag, "_count"}, {28'd0, count}, 32'd0);
        chk({tag, "_overflow"}, {31'd0, overflow}, 32'd0);
        chk({tag, "_frame_err"}, {31'd0, frame_err}, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        // Reset state.
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single frame, read manually.
        send_byte(8'h1C, 1, 1, 0);
        repeat (2) @(negedge clk);
        chk("single_valid", {31'd0, valid}, 32'd1);
        chk("single_data", {24'd0, data}, 32'h1C);
        chk("single_count", {28'd0, count}, 32'd1);
        man_rd = 1'b1;
        @(negedge clk);
        man_rd = 1'b0;
        chk("single_pop_valid", {31'd0, valid}, 32'd0);
        chk("single_pop_count", {28'd0, count}, 32'd0);
        chk("single_no_err", err_cnt, 0);

        // Downstream sequence AA BB CC, read as each arrives.
        auto_read = 1'b1;
        exp_q.push_back(8'hAA); send_byte(8'hAA, 1, 1, 0);
        exp_q.push_back(8'hBB); send_byte(8'hBB, 1, 1, 0);
        exp_q.push_back(8'hCC); send_byte(8'hCC, 1, 1, 0);
        drain();
        chk("seq_detect", {31'd0, (hist == 24'hAABBCC)}, 32'd1);
        chk("seq_no_err", err_cnt, 0);

        // Bad parity, then bad stop, then a good byte.
        send_byte(8'h55, 0, 1, 0);
        chk("badpar_count", {28'd0, count}, 32'd0);
        send_byte(8'h55, 1, 0, 0);
        chk("badstop_count", {28'd0, count}, 32'd0);
        chk("bad_err_pulses", err_cnt, 2);
        exp_q.push_back(8'h12); send_byte(8'h12, 1, 1, 0);
        drain();

        // Overflow: nine frames, no reads.
        auto_read = 1'b0;
        for (int i = 1; i <= FIFO_DEPTH + 1; i++) begin
            if (i <= FIFO_DEPTH) exp_q.push_back(8'(i));
            send_byte(8'(i), 1, 1, 0);
        end
        chk("ovf_count", {28'd0, count}, 32'd8);
        chk("ovf_flag", {31'd0, overflow}, 32'd1);
        auto_read = 1'b1;
        drain();
        chk("ovf_sticky", {31'd0, overflow}, 32'd1);

        // Full FIFO with a pop on the push edge.
        do_reset();
        auto_read = 1'b0;
        for (int i = 1; i <= FIFO_DEPTH; i++) begin
            exp_q.push_back(8'(i));
            send_byte(8'(i), 1, 1, 0);
        end
        chk("full_count", {28'd0, count}, 32'd8);
        chk("full_head", {24'd0, data}, {24'd0, exp_q.pop_front()});
        exp_q.push_back(8'h09);
        send_byte(8'h09, 1, 1, 1);
        chk("pushpop_count", {28'd0, count}, 32'd8);
        chk("pushpop_overflow", {31'd0, overflow}, 32'd0);
        auto_read = 1'b1;
        drain();

        // Timeout after four data bits.
        send_bits({7'b0, 4'b0110}, 5, 0);
        repeat (150) @(negedge clk);
        chk("timeout_not_early", err_cnt, 2);
        begin
            int n = 0;
            while (err_cnt == 2 && n < 300) begin
                @(negedge clk);
                n++;
            end
        end
        chk("timeout_err", err_cnt, 3);
        exp_q.push_back(8'h3A); send_byte(8'h3A, 1, 1, 0);
        drain();

        // Reset mid-frame with a byte already buffered.
        auto_read = 1'b0;
        send_byte(8'h77, 1, 1, 0);
        chk("pre_reset_count", {28'd0, count}, 32'd1);
        send_bits({7'b0, 4'b1010}, 4, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        auto_read = 1'b1;
        exp_q.push_back(8'h5E); send_byte(8'h5E, 1, 1, 0);
        drain();
        chk("final_err_count", err_cnt, 3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Global bound so the run always ends.
    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
